// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I decode types: control bundle, opcodes, ALU
//               control codes and ALU operand-select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU control: {m_op, func7[5], func3}
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;

    // ALU operand A / B selects
    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic       SRC_B_RS2  = 1'b0;
    localparam logic       SRC_B_IMM  = 1'b1;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [4:0] alu_ctrl;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       mem_to_reg;
        logic       branch;
        logic [2:0] br_func3;
        logic       jal;
        logic       jalr;
        logic       reg_write;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator (I/S/B/U/J formats),
//               sign-extended from instr[31] to XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Select the immediate format from the opcode; 32-bit result first
    always_comb begin
        imm32 = 32'd0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'd0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            default:
                imm32 = 32'd0;
        endcase
    end

    // Widen to XLEN; a zero-width replication is avoided for XLEN == 32
    generate
        if (XLEN == 32) begin : g_xlen32
            assign imm = imm32;
        end else begin : g_xlen_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I(M) decode stage with immediate generation,
//               illegal detection, load-use interlock and ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int EN_M  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_imm,
    output ctrl_t            ex_ctrl,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = if_instr[6:0];
    assign f3     = if_instr[14:12];
    assign f7     = if_instr[31:25];

    logic [XLEN-1:0] dec_imm;
    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (dec_imm)
    );

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  uses_rs1, uses_rs2, uses_rd;

    // Instruction decode: control bundle, register usage and legality
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        uses_rd     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_ctrl.alu_src_a = SRC_A_ZERO;
                dec_ctrl.alu_src_b = SRC_B_IMM;
                dec_ctrl.reg_write = 1'b1;
                uses_rd            = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl.alu_src_a = SRC_A_PC;
                dec_ctrl.alu_src_b = SRC_B_IMM;
                dec_ctrl.reg_write = 1'b1;
                uses_rd            = 1'b1;
            end
            OPC_JAL: begin
                dec_ctrl.alu_src_a = SRC_A_PC;
                dec_ctrl.alu_src_b = SRC_B_IMM;
                dec_ctrl.jal       = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                uses_rd            = 1'b1;
            end
            OPC_JALR: begin
                dec_ctrl.alu_src_b = SRC_B_IMM;
                dec_ctrl.jalr      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                uses_rs1           = 1'b1;
                uses_rd            = 1'b1;
                dec_illegal        = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_ctrl.branch   = 1'b1;
                dec_ctrl.br_func3 = f3;
                uses_rs1          = 1'b1;
                uses_rs2          = 1'b1;
                case (f3[2:1])
                    2'b00:   dec_ctrl.alu_ctrl = ALU_SUB;
                    2'b10:   dec_ctrl.alu_ctrl = ALU_SLT;
                    2'b11:   dec_ctrl.alu_ctrl = ALU_SLTU;
                    default: dec_illegal       = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_ctrl.alu_src_b    = SRC_B_IMM;
                dec_ctrl.mem_read     = 1'b1;
                dec_ctrl.mem_to_reg   = 1'b1;
                dec_ctrl.reg_write    = 1'b1;
                dec_ctrl.mem_size     = f3[1:0];
                dec_ctrl.mem_unsigned = f3[2];
                uses_rs1              = 1'b1;
                uses_rd               = 1'b1;
                dec_illegal           = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_ctrl.alu_src_b = SRC_B_IMM;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.mem_size  = f3[1:0];
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
                dec_illegal        = (f3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                dec_ctrl.alu_src_b = SRC_B_IMM;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_ctrl  = {2'b00, f3};
                uses_rs1           = 1'b1;
                uses_rd            = 1'b1;
                // Only shifts constrain func7; only SRAI sets the SUB/SRA bit
                if (f3 == 3'b001) begin
                    dec_illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec_ctrl.alu_ctrl[3] = f7[5];
                    dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                dec_ctrl.reg_write = 1'b1;
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
                uses_rd            = 1'b1;
                if (f7 == 7'b0000000) begin
                    dec_ctrl.alu_ctrl = {2'b00, f3};
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec_ctrl.alu_ctrl = {2'b01, f3};
                end else if (f7 == 7'b0000001 && EN_M != 0) begin
                    dec_ctrl.alu_ctrl = {2'b10, f3};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                // Architecturally a no-op in this in-order pipeline
            end
            default: dec_illegal = 1'b1;
        endcase

        if (if_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end

        // Illegal instructions must not change architectural state
        if (dec_illegal) begin
            dec_ctrl.reg_write = 1'b0;
            dec_ctrl.mem_read  = 1'b0;
            dec_ctrl.mem_write = 1'b0;
            dec_ctrl.branch    = 1'b0;
            dec_ctrl.jal       = 1'b0;
            dec_ctrl.jalr      = 1'b0;
        end
    end

    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    assign dec_rs1 = uses_rs1 ? if_instr[19:15] : 5'd0;
    assign dec_rs2 = uses_rs2 ? if_instr[24:20] : 5'd0;
    assign dec_rd  = uses_rd  ? if_instr[11:7]  : 5'd0;

    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    logic             ex_illegal_q, ex_illegal_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    logic hazard, load_en;

    // Load-use interlock against the instruction currently in ID/EX
    assign hazard  = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) &&
                     ((uses_rs1 && dec_rs1 == ex_rd_q) || (uses_rs2 && dec_rs2 == ex_rd_q));
    assign load_en  = !ex_valid_q || ex_ready;
    assign id_ready = flush || (load_en && !hazard);

    // ID/EX next-state: flush squashes, otherwise capture or insert a bubble
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        ex_imm_d        = ex_imm_q;
        ex_ctrl_d       = ex_ctrl_q;
        ex_illegal_d    = ex_illegal_q;
        illegal_count_d = illegal_count_q;
        if (flush) begin
            ex_valid_d   = 1'b0;
            ex_ctrl_d    = '0;
            ex_illegal_d = 1'b0;
        end else if (load_en) begin
            if (if_valid && !hazard) begin
                ex_valid_d   = 1'b1;
                ex_pc_d      = if_pc;
                ex_rs1_d     = dec_rs1;
                ex_rs2_d     = dec_rs2;
                ex_rd_d      = dec_rd;
                ex_imm_d     = dec_imm;
                ex_ctrl_d    = dec_ctrl;
                ex_illegal_d = dec_illegal;
                if (dec_illegal && illegal_count_q != {CNT_W{1'b1}}) begin
                    illegal_count_d = illegal_count_q + CNT_W'(1);
                end
            end else begin
                ex_valid_d   = 1'b0;
                ex_ctrl_d    = '0;
                ex_illegal_d = 1'b0;
            end
        end
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_imm_q        <= '0;
            ex_ctrl_q       <= '0;
            ex_illegal_q    <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_imm_q        <= ex_imm_d;
            ex_ctrl_q       <= ex_ctrl_d;
            ex_illegal_q    <= ex_illegal_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign ex_imm        = ex_imm_q;
    assign ex_ctrl       = ex_ctrl_q;
    assign ex_illegal    = ex_illegal_q;
    assign illegal_count = illegal_count_q;

endmodule
`default_nettype wire
